// File: rtl/sga_serial_pkg.sv
// Shared definitions for the Snake Game Arcade serial status link (transmitter and receiver).
// Holds the frame layout constants, payload indices and the frame FSM encoding.
package sga_serial_pkg;

    localparam int unsigned FRAME_PAYLOAD_LEN = 4;

    localparam logic [6:0] ASCII_BASE = 7'h30;
    localparam logic [6:0] ASCII_MAX  = 7'h6F;
    localparam logic [6:0] FRAME_TERM = 7'h23;

    localparam logic [1:0] IDX_APPLE = 2'd0;
    localparam logic [1:0] IDX_HEAD  = 2'd1;
    localparam logic [1:0] IDX_STATE = 2'd2;
    localparam logic [1:0] IDX_FLAGS = 2'd3;

    localparam logic [1:0] FR_HUNT    = 2'd0;
    localparam logic [1:0] FR_COLLECT = 2'd1;
    localparam logic [1:0] FR_TERM    = 2'd2;

    typedef struct packed {
        logic [5:0] apple;
        logic [5:0] head;
        logic [5:0] state;
        logic [3:0] flags;
    } sga_status_t;

    function automatic logic is_payload(input logic [6:0] c);
        return (c >= ASCII_BASE) && (c <= ASCII_MAX);
    endfunction

    function automatic logic [5:0] payload_value(input logic [6:0] c);
        logic [6:0] v;
        v = c - ASCII_BASE;
        return v[5:0];
    endfunction

endpackage

// File: rtl/uart_rx_7o1.sv
// 7O1 UART character receiver: 2-FF synchroniser, baud counter and bit FSM.
// Odd parity is only enforced when SGA_RX_PARITY_EN is defined.
module uart_rx_7o1 #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [6:0] char_o,
    output logic       char_ready_o,
    output logic       char_err_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] BIT_IDLE      = 3'd0;
    localparam logic [2:0] BIT_START     = 3'd1;
    localparam logic [2:0] BIT_DATA      = 3'd2;
    localparam logic [2:0] BIT_PARITY    = 3'd3;
    localparam logic [2:0] BIT_STOP      = 3'd4;
    localparam logic [2:0] BIT_WAIT_HIGH = 3'd5;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [6:0]      shift_q, shift_d;
    logic            par_err_q, par_err_d;
    logic            ready, err;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        ready     = 1'b0;
        err       = 1'b0;
        case (state_q)
            BIT_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = BIT_START;
                    cnt_d   = '0;
                end
            end
            BIT_START: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_sync_q ? BIT_IDLE : BIT_DATA;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            BIT_DATA: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[6:1]};
                    if (idx_q == 3'd6) begin
                        state_d = BIT_PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            BIT_PARITY: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    state_d = BIT_STOP;
`ifdef SGA_RX_PARITY_EN
                    par_err_d = ~(^{shift_q, rx_sync_q});
`else
                    par_err_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            BIT_STOP: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d = BIT_IDLE;
                        ready   = ~par_err_q;
                        err     = par_err_q;
                    end else begin
                        // Framing error: hold off until the line returns high.
                        state_d = BIT_WAIT_HIGH;
                        err     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            BIT_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    state_d = BIT_IDLE;
                end
            end
            default: state_d = BIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= BIT_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
        end
    end

    // Strobes are combinational in the stop-sample cycle so the frame layer can register
    // its result in the very next cycle.
    assign char_o       = shift_q;
    assign char_ready_o = ready;
    assign char_err_o   = err;

endmodule

// File: rtl/sga_status_rx.sv
// Snake Game Arcade status stream receiver: reassembles '#'-delimited 4-character frames.
// Define SGA_RX_PARITY_EN to enforce odd parity on each received character.
module sga_status_rx
    import sga_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [5:0] rx_apple,
    output logic [5:0] rx_head,
    output logic [5:0] rx_state,
    output logic [3:0] rx_flags,
    output logic       frame_valid,
    output logic       frame_error,
    output logic [3:0] db_state
);

    logic [6:0]  char_data;
    logic        char_ready, char_err;

    logic [1:0]  fstate_q, fstate_d;
    logic [1:0]  idx_q, idx_d;
    logic [5:0]  shadow_q [FRAME_PAYLOAD_LEN];
    logic [5:0]  shadow_d [FRAME_PAYLOAD_LEN];
    sga_status_t status_q, status_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;

    uart_rx_7o1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .rx_i        (rx),
        .char_o      (char_data),
        .char_ready_o(char_ready),
        .char_err_o  (char_err)
    );

    always_comb begin
        fstate_d = fstate_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        status_d = status_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        if (char_err) begin
            // Line errors while hunting are not frame errors: nothing was in progress.
            if (fstate_q != FR_HUNT) begin
                error_d  = 1'b1;
                fstate_d = FR_HUNT;
                idx_d    = '0;
            end
        end else if (char_ready) begin
            case (fstate_q)
                FR_HUNT: begin
                    if (char_data == FRAME_TERM) begin
                        fstate_d = FR_COLLECT;
                        idx_d    = IDX_APPLE;
                    end
                end
                FR_COLLECT: begin
                    // An early terminator falls outside the payload range too.
                    if (is_payload(char_data)) begin
                        shadow_d[idx_q] = payload_value(char_data);
                        if (idx_q == IDX_FLAGS) begin
                            fstate_d = FR_TERM;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        error_d  = 1'b1;
                        fstate_d = FR_HUNT;
                        idx_d    = '0;
                    end
                end
                FR_TERM: begin
                    if (char_data == FRAME_TERM) begin
                        status_d.apple = shadow_q[IDX_APPLE];
                        status_d.head  = shadow_q[IDX_HEAD];
                        status_d.state = shadow_q[IDX_STATE];
                        status_d.flags = shadow_q[IDX_FLAGS][3:0];
                        valid_d        = 1'b1;
                        fstate_d       = FR_COLLECT;
                        idx_d          = IDX_APPLE;
                    end else begin
                        error_d  = 1'b1;
                        fstate_d = FR_HUNT;
                        idx_d    = '0;
                    end
                end
                default: begin
                    fstate_d = FR_HUNT;
                    idx_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fstate_q <= FR_HUNT;
            idx_q    <= '0;
            status_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            for (int i = 0; i < FRAME_PAYLOAD_LEN; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            fstate_q <= fstate_d;
            idx_q    <= idx_d;
            status_q <= status_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            for (int i = 0; i < FRAME_PAYLOAD_LEN; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign rx_apple    = status_q.apple;
    assign rx_head     = status_q.head;
    assign rx_state    = status_q.state;
    assign rx_flags    = status_q.flags;
    assign frame_valid = valid_q;
    assign frame_error = error_q;
    assign db_state    = {fstate_q, idx_q};

endmodule
